// File: rtl/encoder_velocity_if.sv
// Velocity sample bus between the encoder velocity block and its consumer.
// The master side is the velocity block; the slave side drives count and the ack.
interface encoder_velocity_if;
    logic [15:0] count;
    logic [15:0] vel;
    logic        vel_valid;
    logic        vel_ack;
    logic        overrun;
    logic        stalled;
    logic        sample_tick;

    modport master (
        input  count,
        input  vel_ack,
        output vel,
        output vel_valid,
        output overrun,
        output stalled,
        output sample_tick
    );

    modport slave (
        output count,
        output vel_ack,
        input  vel,
        input  vel_valid,
        input  overrun,
        input  stalled,
        input  sample_tick
    );
endinterface

// File: rtl/encoder_velocity.sv
// Periodic encoder-count sampler producing a signed per-period delta with handshake,
// sticky overrun and stall detection. Define ENC_VEL_AVG_EN for a 4-sample moving average.
module encoder_velocity #(
    parameter int unsigned PERIOD_CYCLES = 18432,
    parameter int unsigned STALL_SAMPLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    encoder_velocity_if.master   bus
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned SCNT_W = 8;
    localparam logic [CNT_W-1:0]  PCNT_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [SCNT_W-1:0] SCNT_MAX  = SCNT_W'(STALL_SAMPLES);

    logic [CNT_W-1:0]  pcnt_q,    pcnt_d;
    logic [CNT_W-1:0]  prev_q,    prev_d;
    logic              primed_q,  primed_d;
    logic [CNT_W-1:0]  vel_q,     vel_d;
    logic              valid_q,   valid_d;
    logic              overrun_q, overrun_d;
    logic [SCNT_W-1:0] scnt_q,    scnt_d;
    logic              stalled_q, stalled_d;
    logic              tick_q,    tick_d;

    logic              tick_c;
    logic              publish_c;
    logic [CNT_W-1:0]  delta_c;
    logic [CNT_W-1:0]  vel_new_c;

`ifdef ENC_VEL_AVG_EN
    localparam int unsigned SUM_W  = 18;
    localparam int unsigned HIST_N = 4;

    logic signed [CNT_W-1:0] hist_q [HIST_N];
    logic signed [CNT_W-1:0] hist_d [HIST_N];
    logic signed [SUM_W-1:0] sum_c;

    // Average of the new delta and the three newest history entries, floored.
    always_comb begin
        sum_c = SUM_W'($signed(delta_c))   + SUM_W'(hist_q[0]) +
                SUM_W'(hist_q[1])          + SUM_W'(hist_q[2]);
        vel_new_c = CNT_W'(sum_c >>> 2);
        for (int i = 0; i < int'(HIST_N); i++) begin
            hist_d[i] = hist_q[i];
        end
        if (publish_c) begin
            for (int i = int'(HIST_N) - 1; i > 0; i--) begin
                hist_d[i] = hist_q[i-1];
            end
            hist_d[0] = $signed(delta_c);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(HIST_N); i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(HIST_N); i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end
`else
    assign vel_new_c = delta_c;
`endif

    assign tick_c    = (pcnt_q == PCNT_LAST);
    assign publish_c = tick_c && primed_q;
    assign delta_c   = bus.count - prev_q;

    // Next-state logic for period timing, handshake and stall tracking.
    always_comb begin
        pcnt_d    = pcnt_q + CNT_W'(1);
        prev_d    = prev_q;
        primed_d  = primed_q;
        vel_d     = vel_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        scnt_d    = scnt_q;
        tick_d    = tick_c;

        if (tick_c) begin
            pcnt_d   = '0;
            prev_d   = bus.count;
            primed_d = 1'b1;
        end

        if (publish_c) begin
            vel_d   = vel_new_c;
            valid_d = 1'b1;
            // An ack in the publish cycle means the old sample was consumed.
            if (valid_q) begin
                overrun_d = !bus.vel_ack;
            end
            if (delta_c == '0) begin
                if (scnt_q != SCNT_MAX) begin
                    scnt_d = scnt_q + SCNT_W'(1);
                end
            end else begin
                scnt_d = '0;
            end
        end else if (valid_q && bus.vel_ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        stalled_d = (scnt_d == SCNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcnt_q    <= '0;
            prev_q    <= '0;
            primed_q  <= 1'b0;
            vel_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            scnt_q    <= '0;
            stalled_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            pcnt_q    <= pcnt_d;
            prev_q    <= prev_d;
            primed_q  <= primed_d;
            vel_q     <= vel_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            scnt_q    <= scnt_d;
            stalled_q <= stalled_d;
            tick_q    <= tick_d;
        end
    end

    assign bus.vel         = vel_q;
    assign bus.vel_valid   = valid_q;
    assign bus.overrun     = overrun_q;
    assign bus.stalled     = stalled_q;
    assign bus.sample_tick = tick_q;

endmodule
